gpr_wb_arbiter: RTL and testbench

Write-back controller for the 32x64 GPR file. It shares the file's single write port between the ALU write-back path and the load/store unit (LSU) load-return path using valid/ready handshakes and round-robin arbitration. A pending-load scoreboard stalls dependent reads and ALU writes that would violate write order. The write port is registered, so the GPR file sees `reg_wen`/`rd`/`rd_wdata` one cycle after grant.

---
 rtl/gpr_pkg.sv | 20 ++
 rtl/gpr_scoreboard.sv | 68 ++++++
 rtl/gpr_wb_arbiter.sv | 110 +++++++++++
 tb/tb_gpr_wb_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_pkg.sv
// Shared types and constants for the GPR write-back path.
// Request data is carried at the full 64-bit width and resized at the top.
package gpr_pkg;

    localparam int NUM_GPR  = 32;
    localparam int GPR_AW   = 5;
    localparam int WB_XLEN  = 64;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_LSU = 1'b1
    } wb_src_e;

    typedef struct packed {
        logic              valid;
        logic [GPR_AW-1:0] rd;
        logic [WB_XLEN-1:0] wdata;
    } wb_req_t;

endpackage

// File: rtl/gpr_scoreboard.sv
// Pending-load scoreboard: one bit per GPR with a load in flight,
// plus the outstanding-load counter that throttles load issue.
module gpr_scoreboard
    import gpr_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              issue_valid,
    input  logic [GPR_AW-1:0] issue_rd,
    output logic              issue_ready,
    input  logic              ret_accept,
    input  logic [GPR_AW-1:0] ret_rd,
    input  logic [GPR_AW-1:0] rs1,
    input  logic [GPR_AW-1:0] rs2,
    input  logic [GPR_AW-1:0] alu_rd,
    output logic              rs1_pending,
    output logic              rs2_pending,
    output logic              alu_rd_pending
);

    localparam int CW = 4;

    logic [NUM_GPR-1:0] pending_q, pending_d;
    logic [CW-1:0]      out_cnt_q, out_cnt_d;
    logic               issue_hs;

    assign issue_ready = (out_cnt_q < CW'(MAX_OUTSTANDING));
    assign issue_hs    = issue_valid && issue_ready;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        pending_d = pending_q;
        out_cnt_d = out_cnt_q;
        if (ret_accept) begin
            pending_d[ret_rd] = 1'b0;
        end
        // Applied after the clear: a fresh load to the same register stays outstanding.
        if (issue_hs && issue_rd != '0) begin
            pending_d[issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;

        unique case ({issue_hs, ret_accept})
            2'b10:   out_cnt_d = out_cnt_q + CW'(1);
            2'b01:   if (out_cnt_q != '0) out_cnt_d = out_cnt_q - CW'(1);
            default: out_cnt_d = out_cnt_q;
        endcase
    end

    // NOTE: the bitmap is a small flop array, not a RAM, so it can and must be reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
            out_cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            pending_q <= pending_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    assign rs1_pending    = pending_q[rs1];
    assign rs2_pending    = pending_q[rs2];
    assign alu_rd_pending = pending_q[alu_rd];

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Write-back controller: round-robin share of the GPR write port between
// ALU and load returns, with a WAW guard and a registered write stage.
module gpr_wb_arbiter
    import gpr_pkg::*;
#(
    parameter int XLEN            = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [GPR_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_wdata,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [GPR_AW-1:0] lsu_rd,
    input  logic [XLEN-1:0]   lsu_wdata,
    input  logic              ld_issue_valid,
    output logic              ld_issue_ready,
    input  logic [GPR_AW-1:0] ld_issue_rd,
    input  logic [GPR_AW-1:0] rs1,
    input  logic [GPR_AW-1:0] rs2,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              reg_wen,
    output logic [GPR_AW-1:0] rd,
    output logic [XLEN-1:0]   rd_wdata
);

    wb_req_t           alu_req, lsu_req, win_req;
    wb_src_e           last_grant_q, last_grant_d;
    logic              alu_eligible, lsu_eligible;
    logic              grant_alu, grant_lsu;
    logic              rs1_pending, rs2_pending, alu_rd_pending;
    logic              reg_wen_q, reg_wen_d;
    logic [GPR_AW-1:0] rd_q, rd_d;
    logic [XLEN-1:0]   rd_wdata_q, rd_wdata_d;

    gpr_scoreboard #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_scoreboard (
        .clock          (clock),
        .reset_n        (reset_n),
        .issue_valid    (ld_issue_valid),
        .issue_rd       (ld_issue_rd),
        .issue_ready    (ld_issue_ready),
        .ret_accept     (grant_lsu),
        .ret_rd         (lsu_rd),
        .rs1            (rs1),
        .rs2            (rs2),
        .alu_rd         (alu_rd),
        .rs1_pending    (rs1_pending),
        .rs2_pending    (rs2_pending),
        .alu_rd_pending (alu_rd_pending)
    );

    always_comb begin
        alu_req = '{valid: alu_valid, rd: alu_rd, wdata: WB_XLEN'(alu_wdata)};
        lsu_req = '{valid: lsu_valid, rd: lsu_rd, wdata: WB_XLEN'(lsu_wdata)};

        // An ALU write must not land before an older load to the same register.
        alu_eligible = alu_req.valid && (alu_req.rd == '0 || !alu_rd_pending);
        lsu_eligible = lsu_req.valid;

        grant_alu = alu_eligible && (!lsu_eligible || last_grant_q == WB_LSU);
        grant_lsu = lsu_eligible && (!alu_eligible || last_grant_q == WB_ALU);

        win_req      = '0;
        last_grant_d = last_grant_q;
        if (grant_lsu) begin
            win_req      = lsu_req;
            last_grant_d = WB_LSU;
        end else if (grant_alu) begin
            win_req      = alu_req;
            last_grant_d = WB_ALU;
        end

        reg_wen_d  = win_req.valid && (win_req.rd != '0);
        rd_d       = win_req.valid ? win_req.rd : rd_q;
        rd_wdata_d = win_req.valid ? XLEN'(win_req.wdata) : rd_wdata_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= WB_ALU;
            reg_wen_q    <= 1'b0;
            rd_q         <= '0;
            rd_wdata_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            reg_wen_q    <= reg_wen_d;
            rd_q         <= rd_d;
            rd_wdata_q   <= rd_wdata_d;
        end
    end

    // A source is busy while its load is in flight or its write has not reached the file.
    assign rs1_busy = (rs1 != '0) && (rs1_pending || (reg_wen_q && rd_q == rs1)
                                      || (win_req.valid && win_req.rd == rs1));
    assign rs2_busy = (rs2 != '0) && (rs2_pending || (reg_wen_q && rd_q == rs2)
                                      || (win_req.valid && win_req.rd == rs2));

    assign alu_ready = grant_alu;
    assign lsu_ready = grant_lsu;
    assign reg_wen   = reg_wen_q;
    assign rd        = rd_q;
    assign rd_wdata  = rd_wdata_q;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Bench for gpr_wb_arbiter: per-cycle vector table for handshakes and busy flags,
// a write-back queue checked against the registered write port, and an async-reset sequence.
module tb_gpr_wb_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [63:0] alu_wdata;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [63:0] lsu_wdata;
    logic        ld_issue_valid, ld_issue_ready;
    logic [4:0]  ld_issue_rd;
    logic [4:0]  rs1, rs2;
    logic        rs1_busy, rs2_busy;
    logic        reg_wen;
    logic [4:0]  rd;
    logic [63:0] rd_wdata;

    gpr_wb_arbiter #(
        .XLEN            (64),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .alu_valid      (alu_valid),
        .alu_ready      (alu_ready),
        .alu_rd         (alu_rd),
        .alu_wdata      (alu_wdata),
        .lsu_valid      (lsu_valid),
        .lsu_ready      (lsu_ready),
        .lsu_rd         (lsu_rd),
        .lsu_wdata      (lsu_wdata),
        .ld_issue_valid (ld_issue_valid),
        .ld_issue_ready (ld_issue_ready),
        .ld_issue_rd    (ld_issue_rd),
        .rs1            (rs1),
        .rs2            (rs2),
        .rs1_busy       (rs1_busy),
        .rs2_busy       (rs2_busy),
        .reg_wen        (reg_wen),
        .rd             (rd),
        .rd_wdata       (rd_wdata)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [63:0] awd;
        logic        lv;
        logic [4:0]  lrd;
        logic [63:0] lwd;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        e_ar;
        logic        e_lr;
        logic        e_ir;
        logic        e_b1;
        logic        e_b2;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } wb_exp_t;

    vec_t    vecs[$];
    wb_exp_t exp_q[$];
    wb_exp_t mon_e;
    int      n_checks = 0;
    int      n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [63:0] awd,
                                input logic lv, input logic [4:0] lrd, input logic [63:0] lwd,
                                input logic iv, input logic [4:0] ird,
                                input logic [4:0] r1, input logic [4:0] r2,
                                input logic e_ar, input logic e_lr, input logic e_ir,
                                input logic e_b1, input logic e_b2);
        vec_t v;
        v = '{av, ard, awd, lv, lrd, lwd, iv, ird, r1, r2, e_ar, e_lr, e_ir, e_b1, e_b2};
        return v;
    endfunction

    task automatic drive_idle();
        alu_valid = 0; alu_rd = 0; alu_wdata = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_wdata = 0;
        ld_issue_valid = 0; ld_issue_rd = 0;
        rs1 = 0; rs2 = 0;
    endtask

    // Every registered write must match the oldest expected write-back.
    always @(negedge clock) begin
        if (reset_n && reg_wen) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL wb_unexpected: got rd=%0d data=%h, expected no write", rd, rd_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("wb_rd", 64'(rd), 64'(mon_e.rd));
                check("wb_data", rd_wdata, mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        //          alu            lsu              issue  rs1 rs2  ar lr ir b1 b2
        // load x5, busy, return 0xDEAD, busy through write stage
        vecs.push_back(mk(0, 0, 0,      0, 0, 0,       1, 5,  5, 0,   0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,      0, 0, 0,       0, 0,  5, 0,   0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0,      1, 5, 'hDEAD,  0, 0,  5, 0,   0, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0,      0, 0, 0,       0, 0,  5, 0,   0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0,      0, 0, 0,       0, 0,  5, 0,   0, 0, 1, 0, 0));
        // ALU alone sets last_grant=ALU, then both requesting alternate
        vecs.push_back(mk(1, 3, 'h33,   0, 0, 0,       0, 0,  0, 0,   1, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 'h101,  1, 2, 'h201,   0, 0,  1, 2,   0, 1, 1, 0, 1));
        vecs.push_back(mk(1, 1, 'h101,  1, 2, 'h202,   0, 0,  1, 2,   1, 0, 1, 1, 1));
        vecs.push_back(mk(1, 1, 'h102,  1, 2, 'h202,   0, 0,  1, 2,   0, 1, 1, 1, 1));
        vecs.push_back(mk(1, 1, 'h102,  1, 2, 'h203,   0, 0,  1, 2,   1, 0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0,      0, 0, 0,       0, 0,  0, 0,   0, 0, 1, 0, 0));
        // WAW guard: ALU to x7 blocked until the x7 load returns
        vecs.push_back(mk(0, 0, 0,      0, 0, 0,       1, 7,  0, 0,   0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 7, 'hA7,   0, 0, 0,       0, 0,  7, 0,   0, 0, 1, 1, 0));
        vecs.push_back(mk(1, 7, 'hA7,   0, 0, 0,       0, 0,  7, 0,   0, 0, 1, 1, 0));
        vecs.push_back(mk(1, 7, 'hA7,   1, 7, 'h77,    0, 0,  7, 0,   0, 1, 1, 1, 0));
        vecs.push_back(mk(1, 7, 'hA7,   0, 0, 0,       0, 0,  7, 0,   1, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0,      0, 0, 0,       0, 0,  7, 0,   0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0,      0, 0, 0,       0, 0,  7, 0,   0, 0, 1, 0, 0));
        // outstanding limit: issue+return together holds the count
        vecs.push_back(mk(0, 0, 0,      0, 0, 0,       1, 10, 0, 0,   0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,      0, 0, 0,       1, 11, 0, 0,   0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,      0, 0, 0,       1, 12, 0, 0,   0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,      1, 10, 'h1010, 1, 13, 10, 0,  0, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0,      0, 0, 0,       1, 14, 13, 0,  0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0,      0, 0, 0,       1, 15, 14, 15, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0,      0, 0, 0,       0, 0,  13, 15, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0,      1, 11, 'h1111, 1, 15, 11, 15, 0, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0,      0, 0, 0,       0, 0,  11, 15, 0, 0, 1, 1, 0));
        // issue and return to x12 in one cycle: x12 stays pending
        vecs.push_back(mk(0, 0, 0,      1, 12, 'h1212, 1, 12, 12, 0,  0, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0,      0, 0, 0,       0, 0,  12, 0,  0, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0,      0, 0, 0,       0, 0,  12, 11, 0, 0, 1, 1, 0));
        // x0 writes and loads: accepted but never written nor pending
        vecs.push_back(mk(1, 0, 'h1234, 0, 0, 0,       0, 0,  0, 13,  1, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0,      0, 0, 0,       1, 0,  0, 0,   0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,      0, 0, 0,       0, 0,  0, 14,  0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 'h5678, 0, 0, 0,       0, 0,  0, 0,   1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,      0, 0, 0,       0, 0,  0, 0,   0, 0, 0, 0, 0));

        reset_n = 1'b0;
        drive_idle();
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        rs1 = 5;
        #2;
        check("reset reg_wen", 64'(reg_wen), 0);
        check("reset rd", 64'(rd), 0);
        check("reset rd_wdata", rd_wdata, 0);
        check("reset alu_ready", 64'(alu_ready), 0);
        check("reset lsu_ready", 64'(lsu_ready), 0);
        check("reset ld_issue_ready", 64'(ld_issue_ready), 1);
        check("reset rs1_busy", 64'(rs1_busy), 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            alu_valid = vecs[i].av;  alu_rd = vecs[i].ard;  alu_wdata = vecs[i].awd;
            lsu_valid = vecs[i].lv;  lsu_rd = vecs[i].lrd;  lsu_wdata = vecs[i].lwd;
            ld_issue_valid = vecs[i].iv;  ld_issue_rd = vecs[i].ird;
            rs1 = vecs[i].r1;  rs2 = vecs[i].r2;
            #2;
            check($sformatf("v%0d alu_ready", i), 64'(alu_ready), 64'(vecs[i].e_ar));
            check($sformatf("v%0d lsu_ready", i), 64'(lsu_ready), 64'(vecs[i].e_lr));
            check($sformatf("v%0d ld_issue_ready", i), 64'(ld_issue_ready), 64'(vecs[i].e_ir));
            check($sformatf("v%0d rs1_busy", i), 64'(rs1_busy), 64'(vecs[i].e_b1));
            check($sformatf("v%0d rs2_busy", i), 64'(rs2_busy), 64'(vecs[i].e_b2));
            if (vecs[i].e_ar && vecs[i].ard != 0)
                exp_q.push_back('{rd: vecs[i].ard, data: vecs[i].awd});
            if (vecs[i].e_lr && vecs[i].lrd != 0)
                exp_q.push_back('{rd: vecs[i].lrd, data: vecs[i].lwd});
        end

        // rd/rd_wdata keep the last granted (x0) write through idle cycles
        @(negedge clock);
        drive_idle();
        #2;
        check("hold reg_wen", 64'(reg_wen), 0);
        check("hold rd", 64'(rd), 0);
        check("hold rd_wdata", rd_wdata, 64'h5678);

        // async reset with loads outstanding and a write in the write stage
        @(negedge clock);
        alu_valid = 1; alu_rd = 20; alu_wdata = 64'h2020;
        #2;
        check("pre-reset alu_ready", 64'(alu_ready), 1);
        @(posedge clock);
        #1;
        check("pre-reset reg_wen", 64'(reg_wen), 1);
        check("pre-reset rd", 64'(rd), 20);
        alu_valid = 0;
        rs1 = 12; rs2 = 14;
        reset_n = 1'b0;
        #1;
        check("async reset reg_wen", 64'(reg_wen), 0);
        check("async reset rd", 64'(rd), 0);
        check("async reset rd_wdata", rd_wdata, 0);
        check("async reset ld_issue_ready", 64'(ld_issue_ready), 1);
        check("async reset rs1_busy", 64'(rs1_busy), 0);
        check("async reset rs2_busy", 64'(rs2_busy), 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        #2;
        check("post-reset rs1_busy", 64'(rs1_busy), 0);
        check("post-reset ld_issue_ready", 64'(ld_issue_ready), 1);
        check("wb queue drained", 64'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
